// File: rtl/bmem_unloader_if.sv
// BMEM read port plus UART write channel seen by the block unloader.
// master = unloader side, slave = blockmem/uart_controller side.
interface bmem_unloader_if #(
  parameter int unsigned BITWIDTH = 32,
  parameter int unsigned NWORDS   = 16
);
  logic [BITWIDTH-1:0]        bmem_addr;
  logic [BITWIDTH*NWORDS-1:0] bmem_data;
  logic                       write_lock_req;
  logic                       write_lock_res;
  logic                       write_ready;
  logic [7:0]                 write_data;
  logic                       write_data_valid;

  modport master (
    output bmem_addr,
    output write_lock_req,
    output write_data,
    output write_data_valid,
    input  bmem_data,
    input  write_lock_res,
    input  write_ready
  );

  modport slave (
    input  bmem_addr,
    input  write_lock_req,
    input  write_data,
    input  write_data_valid,
    output bmem_data,
    output write_lock_res,
    output write_ready
  );
endinterface

// File: rtl/bmem_unloader.sv
// Reads one BMEM tile block and streams it over a locked UART write channel
// as header 0x80, block address, then words, every multi-byte field LSB first.
module bmem_unloader #(
  parameter int unsigned BITWIDTH  = 32,
  parameter int unsigned MESHUNITS = 2,
  parameter int unsigned TILEUNITS = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BITWIDTH-1:0] start_addr,
  output logic                busy,
  output logic                done,
  bmem_unloader_if.master     bus
);

  localparam int unsigned B      = BITWIDTH / 8;
  localparam int unsigned NWords = MESHUNITS * MESHUNITS * TILEUNITS * TILEUNITS;
  localparam int unsigned NBytes = 1 + B + B * NWords;
  localparam int unsigned CtrW   = $clog2(NBytes + 1);
  localparam int unsigned FrameW = 8 * NBytes;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StCapture,
    StLock,
    StSend,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [BITWIDTH-1:0] addr_q, addr_d;
  logic [FrameW-1:0]   frame_q, frame_d;
  logic [CtrW-1:0]     byte_ctr_q, byte_ctr_d;
  logic                xfer;

  assign xfer = (state_q == StSend) && bus.write_lock_res && bus.write_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    frame_d    = frame_q;
    byte_ctr_d = byte_ctr_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = start_addr;
          state_d = StRead;
        end
      end
      StRead: state_d = StCapture;
      StCapture: begin
        // Whole frame captured at once; the byte at [7:0] is always the next one to send.
        frame_d    = {bus.bmem_data, addr_q, 8'h80};
        byte_ctr_d = '0;
        state_d    = StLock;
      end
      StLock: begin
        if (bus.write_lock_res) state_d = StSend;
      end
      StSend: begin
        if (xfer) begin
          frame_d    = frame_q >> 8;
          byte_ctr_d = byte_ctr_q + CtrW'(1);
          if (byte_ctr_q == CtrW'(NBytes - 1)) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      frame_q    <= '0;
      byte_ctr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      frame_q    <= frame_d;
      byte_ctr_q <= byte_ctr_d;
    end
  end

  // Outputs decode straight from state so an asynchronous reset clears them immediately.
  always_comb begin
    busy                 = (state_q != StIdle);
    done                 = (state_q == StDone);
    bus.bmem_addr        = addr_q;
    bus.write_lock_req   = (state_q == StLock) || (state_q == StSend);
    bus.write_data_valid = (state_q == StSend) && bus.write_lock_res;
    bus.write_data       = (state_q == StSend) ? frame_q[7:0] : 8'h00;
  end

endmodule

// File: tb/tb_bmem_unloader.sv
// Directed-sequence bench for bmem_unloader with randomized block contents,
// checked against a byte-queue reference built from the stream format.
module tb_bmem_unloader;

  localparam int unsigned BW = 32;
  localparam int unsigned NW = 16;
  localparam int unsigned NB = 1 + 4 + 4 * NW;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] start_addr = '0;
  logic          busy;
  logic          done;

  bmem_unloader_if #(.BITWIDTH(BW), .NWORDS(NW)) bus ();

  bmem_unloader #(
    .BITWIDTH (BW),
    .MESHUNITS(2),
    .TILEUNITS(2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .start_addr(start_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  logic [7:0]       got[$];
  logic [7:0]       exp_q[$];
  int               done_cnt = 0;
  logic [BW-1:0]    cur_addr = '0;
  logic [BW-1:0]    words[NW];
  logic [BW*NW-1:0] cur_block = '0;
  int               ready_mode = 0;
  bit               lock_en = 1'b0;
  bit               gap_armed = 1'b0;
  bit               gap_used = 1'b0;
  int               gap_left = 0;
  int               cyc = 0;
  bit               hold_pend = 1'b0;
  logic [7:0]       hold_byte = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // BMEM model: registered read, correct block only for the address presented a cycle earlier.
  always @(posedge clock) begin
    bus.bmem_data <= (bus.bmem_addr == cur_addr) ? cur_block : ~cur_block;
  end

  // UART side: ready pattern, lock grant on request, optional 5-cycle revocation after byte 20.
  always @(posedge clock) begin
    #1;
    cyc++;
    case (ready_mode)
      0:       bus.write_ready = 1'b1;
      1:       bus.write_ready = ((cyc / 3) % 2) == 0;
      default: bus.write_ready = 1'($urandom_range(0, 1));
    endcase
    if (gap_armed && !gap_used && got.size() == 21) begin
      gap_left = 5;
      gap_used = 1'b1;
    end
    if (gap_left > 0) begin
      gap_left--;
      bus.write_lock_res = 1'b0;
    end else begin
      bus.write_lock_res = lock_en && bus.write_lock_req;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      if (hold_pend && bus.write_data_valid) check("hold_stable", bus.write_data, hold_byte);
      hold_pend = bus.write_data_valid && !bus.write_ready;
      hold_byte = bus.write_data;
      if (!bus.write_lock_res && busy) check("valid_gated", bus.write_data_valid, 0);
      if (bus.write_data_valid && bus.write_ready && bus.write_lock_res)
        got.push_back(bus.write_data);
      if (done) done_cnt++;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic load_block(input logic [BW-1:0] a, input bit nominal);
    cur_addr = a;
    for (int i = 0; i < NW; i++) begin
      words[i] = nominal ? (32'hA0 + 32'(i)) : $urandom;
      cur_block[i*BW+:BW] = words[i];
    end
  endtask

  task automatic build_exp(input logic [BW-1:0] a);
    exp_q.delete();
    exp_q.push_back(8'h80);
    for (int b = 0; b < 4; b++) exp_q.push_back(a[8*b+:8]);
    for (int w = 0; w < NW; w++)
      for (int b = 0; b < 4; b++) exp_q.push_back(words[w][8*b+:8]);
  endtask

  task automatic compare(input string tag);
    check({tag, "_len"}, got.size(), NB);
    for (int i = 0; i < NB && i < got.size(); i++)
      check($sformatf("%s_b%0d", tag, i), got[i], exp_q[i]);
  endtask

  task automatic do_start(input logic [BW-1:0] a);
    @(posedge clock);
    #1;
    start = 1'b1;
    start_addr = a;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge clock);
      seen = done;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic after_done(input string tag);
    @(negedge clock);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_req_drop"}, bus.write_lock_req, 0);
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic wait_bytes(input int n, input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clock);
      ok = (got.size() >= n);
    end
    check({tag, "_reached"}, ok, 1);
  endtask

  task automatic run_stream(input string tag, input logic [BW-1:0] a);
    int d0;
    load_block(a, 1'b0);
    got.delete();
    d0 = done_cnt;
    do_start(a);
    wait_done(tag);
    build_exp(a);
    compare(tag);
    after_done(tag);
    check({tag, "_one_done"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    bus.write_ready    = 1'b1;
    bus.write_lock_res = 1'b0;

    // Reset and idle state
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", bus.write_lock_req, 0);
    check("rst_valid", bus.write_data_valid, 0);
    check("rst_data", bus.write_data, 0);
    check("rst_addr", bus.bmem_addr, 0);

    // Latency to lock request, then indefinite wait with no grant
    load_block(32'h10, 1'b1);
    got.delete();
    d0 = done_cnt;
    lock_en = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b1;
    start_addr = 32'h10;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("lat_t1_busy", busy, 1);
    check("lat_t1_req", bus.write_lock_req, 0);
    check("lat_t1_addr", bus.bmem_addr, 32'h10);
    @(posedge clock);
    #1;
    check("lat_t2_req", bus.write_lock_req, 0);
    @(posedge clock);
    #1;
    check("lat_t3_req", bus.write_lock_req, 1);
    repeat (20) @(negedge clock);
    check("lockwait_req", bus.write_lock_req, 1);
    check("lockwait_busy", busy, 1);
    check("lockwait_valid", bus.write_data_valid, 0);
    check("lockwait_nodone", done_cnt - d0, 0);

    // Nominal dump once the lock is granted
    lock_en = 1'b1;
    wait_done("nominal");
    build_exp(32'h10);
    compare("nominal");
    after_done("nominal");
    check("nominal_one_done", done_cnt - d0, 1);

    // Backpressure, random ready, lock revocation
    ready_mode = 1;
    run_stream("backpressure", $urandom);
    ready_mode = 2;
    run_stream("rand_ready", $urandom);
    ready_mode = 0;
    gap_armed = 1'b1;
    gap_used = 1'b0;
    run_stream("lockgap", $urandom);
    gap_armed = 1'b0;

    // Start while busy is dropped; start right after done is taken
    load_block(32'h10, 1'b0);
    got.delete();
    d0 = done_cnt;
    do_start(32'h10);
    wait_bytes(10, "busy_mid");
    do_start(32'h20);
    wait_done("busy_start");
    build_exp(32'h10);
    compare("busy_start");
    load_block(32'h20, 1'b0);
    got.delete();
    do_start(32'h20);
    wait_done("b2b");
    build_exp(32'h20);
    compare("b2b");
    after_done("b2b");
    check("b2b_two_done", done_cnt - d0, 2);

    // Asynchronous reset mid-send, then a fresh full stream
    load_block($urandom, 1'b0);
    got.delete();
    do_start(cur_addr);
    wait_bytes(30, "arst_mid");
    #2 reset = 1'b0;
    #1;
    check("arst_req", bus.write_lock_req, 0);
    check("arst_valid", bus.write_data_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", bus.bmem_addr, 0);
    @(posedge clock);
    #1 reset = 1'b1;
    run_stream("after_reset", $urandom);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
